// File: rtl/tl_pkg.sv
// tl_pkg: shared state codes, lamp bit indices and phase-select encoding for the traffic light
package tl_pkg;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALL_R1 = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        ALL_R2 = 3'd5,
        FLASH  = 3'd6
    } tl_state_t;

    localparam int LAMP_R = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_G = 0;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // phase select packed as {fsm_g, fsm_y, fsm_r}
    localparam logic [2:0] PH_G = 3'b100;
    localparam logic [2:0] PH_Y = 3'b010;
    localparam logic [2:0] PH_R = 3'b001;

endpackage

// File: rtl/tl_flash_blink.sv
// tl_flash_blink: blink toggle register; toggles while run is high, clears when run is low
module tl_flash_blink #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic blink
);

    // entering run from a cleared register yields 1 on the first run cycle
    always_ff @(posedge clk)
        if (rst) blink <= RST_VAL;
        else     blink <= run ? ~blink : 1'b0;

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road traffic light controller with night flash; macro SIDE_SENSOR_EN adds side_req demand sensing
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter bit FLASH_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       g_end,
    input  logic       y_end,
    input  logic       r_end,
    input  logic       flash_req,
`ifdef SIDE_SENSOR_EN
    input  logic       side_req,
`endif
    output logic       fsm_g,
    output logic       fsm_y,
    output logic       fsm_r,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic [2:0] state
);

    tl_state_t  cur, nxt;
    logic       blink, side_go;
    logic [2:0] phase, flash_lamp;

`ifdef SIDE_SENSOR_EN
    logic side_wait;
    // sticky side demand; clearing on entry to SIDE_G wins over a simultaneous set
    always_ff @(posedge clk)
        if (rst)                                side_wait <= 1'b0;
        else if (nxt == SIDE_G && cur != SIDE_G) side_wait <= 1'b0;
        else if (side_req)                      side_wait <= 1'b1;
    assign side_go = side_wait | side_req;
`else
    assign side_go = 1'b1;
`endif

    // state register; reset overrides every input on its edge
    always_ff @(posedge clk)
        if (rst) cur <= FLASH_ON_RESET ? FLASH : ALL_R2;
        else     cur <= nxt;

    // next state: only the end pulse of the current phase advances; flash_req only taken at an all-red r_end
    always_comb begin
        nxt = cur;
        case (cur)
            MAIN_G:  nxt = g_end ? MAIN_Y : MAIN_G;
            MAIN_Y:  nxt = y_end ? ALL_R1 : MAIN_Y;
            ALL_R1:  nxt = !r_end ? ALL_R1 : flash_req ? FLASH : side_go ? SIDE_G : MAIN_G;
            SIDE_G:  nxt = g_end ? SIDE_Y : SIDE_G;
            SIDE_Y:  nxt = y_end ? ALL_R2 : SIDE_Y;
            ALL_R2:  nxt = !r_end ? ALL_R2 : flash_req ? FLASH : MAIN_G;
            FLASH:   nxt = flash_req ? FLASH : ALL_R1;
            default: nxt = ALL_R2;
        endcase
    end

    tl_flash_blink #(.RST_VAL(FLASH_ON_RESET)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .run   (nxt == FLASH),
        .blink (blink)
    );

    // Moore decode from the state and blink registers only
    always_comb begin
        flash_lamp         = '0;
        flash_lamp[LAMP_Y] = blink;
        phase     = (cur == MAIN_G || cur == SIDE_G) ? PH_G :
                    (cur == MAIN_Y || cur == SIDE_Y) ? PH_Y : PH_R;
        main_lamp = cur == MAIN_G ? LAMP_GRN : cur == MAIN_Y ? LAMP_YEL :
                    cur == FLASH  ? flash_lamp : LAMP_RED;
        side_lamp = cur == SIDE_G ? LAMP_GRN : cur == SIDE_Y ? LAMP_YEL :
                    cur == FLASH  ? flash_lamp : LAMP_RED;
    end

    assign {fsm_g, fsm_y, fsm_r} = phase;
    assign state = cur;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: table-driven directed checks of traffic_light_fsm plus flash-on-reset and side-sensor sequences
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       rst, g_end, y_end, r_end, flash_req, side_req;
    logic       fsm_g, fsm_y, fsm_r;
    logic [2:0] main_lamp, side_lamp, state;

    logic       rst_f, flash_f;
    logic       fg_f, fy_f, fr_f;
    logic [2:0] ml_f, sl_f, st_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk(clk), .rst(rst), .g_end(g_end), .y_end(y_end), .r_end(r_end), .flash_req(flash_req),
`ifdef SIDE_SENSOR_EN
        .side_req(side_req),
`endif
        .fsm_g(fsm_g), .fsm_y(fsm_y), .fsm_r(fsm_r),
        .main_lamp(main_lamp), .side_lamp(side_lamp), .state(state)
    );

    traffic_light_fsm #(.FLASH_ON_RESET(1'b1)) dut_f (
        .clk(clk), .rst(rst_f), .g_end(1'b0), .y_end(1'b0), .r_end(1'b0), .flash_req(flash_f),
`ifdef SIDE_SENSOR_EN
        .side_req(1'b0),
`endif
        .fsm_g(fg_f), .fsm_y(fy_f), .fsm_r(fr_f),
        .main_lamp(ml_f), .side_lamp(sl_f), .state(st_f)
    );

    typedef struct {
        logic       rst, g, y, r, f, s;
        logic [2:0] st, ml, sl, ph;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rs, g, y, r, f, s,
                                input logic [2:0] st, ml, sl, ph);
        vec_t v;
        v.rst = rs; v.g = g; v.y = y; v.r = r; v.f = f; v.s = s;
        v.st = st; v.ml = ml; v.sl = sl; v.ph = ph;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, g, y, r, f, s);
        @(negedge clk);
        rst = rs; g_end = g; y_end = y; r_end = r; flash_req = f; side_req = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [2:0] st, ml, sl, ph);
        chk({tag, " state"}, state, st);
        chk({tag, " main_lamp"}, main_lamp, ml);
        chk({tag, " side_lamp"}, side_lamp, sl);
        chk({tag, " phase"}, {fsm_g, fsm_y, fsm_r}, ph);
        chk({tag, " both_green"}, {2'b00, main_lamp[0] & side_lamp[0]}, 3'b000);
    endtask

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;
    localparam logic [2:0] PG = 3'b100, PY = 3'b010, PR = 3'b001;

    initial begin
        rst = 1'b1; g_end = 0; y_end = 0; r_end = 0; flash_req = 0; side_req = 0;
        rst_f = 1'b1; flash_f = 1'b1;

        //             rst g y r f s   state  main side phase
        vecs.push_back(mk(1, 0,0,0,0,0, 3'd5, R, R, PR));
        vecs.push_back(mk(0, 0,0,0,0,0, 3'd5, R, R, PR));
        vecs.push_back(mk(0, 1,1,0,0,0, 3'd5, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,0,0, 3'd0, G, R, PG));
        vecs.push_back(mk(0, 0,1,1,0,0, 3'd0, G, R, PG));
        vecs.push_back(mk(0, 1,0,0,0,0, 3'd1, Y, R, PY));
        vecs.push_back(mk(0, 1,0,1,0,0, 3'd1, Y, R, PY));
        vecs.push_back(mk(0, 0,1,0,0,0, 3'd2, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,0,1, 3'd3, R, G, PG));
        vecs.push_back(mk(0, 0,1,1,0,0, 3'd3, R, G, PG));
        vecs.push_back(mk(0, 1,0,0,0,0, 3'd4, R, Y, PY));
        vecs.push_back(mk(0, 0,1,0,0,0, 3'd5, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,0,0, 3'd0, G, R, PG));
        vecs.push_back(mk(0, 1,0,0,1,0, 3'd1, Y, R, PY));
        vecs.push_back(mk(0, 0,1,0,1,0, 3'd2, R, R, PR));
        vecs.push_back(mk(0, 0,0,0,1,0, 3'd2, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,1,0, 3'd6, Y, Y, PR));
        vecs.push_back(mk(0, 0,0,1,1,0, 3'd6, O, O, PR));
        vecs.push_back(mk(0, 0,0,0,1,0, 3'd6, Y, Y, PR));
        vecs.push_back(mk(0, 0,0,0,0,0, 3'd2, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,0,1, 3'd3, R, G, PG));
        vecs.push_back(mk(0, 1,0,0,0,0, 3'd4, R, Y, PY));
        vecs.push_back(mk(1, 0,1,0,1,0, 3'd5, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,1,0, 3'd6, Y, Y, PR));
        vecs.push_back(mk(0, 0,0,0,1,0, 3'd6, O, O, PR));
        vecs.push_back(mk(1, 0,0,0,1,0, 3'd5, R, R, PR));
        vecs.push_back(mk(0, 0,0,1,0,0, 3'd0, G, R, PG));

        foreach (vecs[i])
            begin
                drive(vecs[i].rst, vecs[i].g, vecs[i].y, vecs[i].r, vecs[i].f, vecs[i].s);
                check_main($sformatf("vec%0d", i), vecs[i].st, vecs[i].ml, vecs[i].sl, vecs[i].ph);
            end

`ifdef SIDE_SENSOR_EN
        drive(0, 1,0,0,0,0); check_main("ss_my", 3'd1, Y, R, PY);
        drive(0, 0,1,0,0,0); check_main("ss_r1", 3'd2, R, R, PR);
        drive(0, 0,0,1,0,0); check_main("ss_skip", 3'd0, G, R, PG);
        drive(0, 1,0,0,0,0); check_main("ss_my2", 3'd1, Y, R, PY);
        drive(0, 0,0,0,0,1); check_main("ss_pulse", 3'd1, Y, R, PY);
        drive(0, 0,1,0,0,0); check_main("ss_r1b", 3'd2, R, R, PR);
        drive(0, 0,0,1,0,0); check_main("ss_sideg", 3'd3, R, G, PG);
        drive(0, 1,0,0,0,0); check_main("ss_sidey", 3'd4, R, Y, PY);
        drive(0, 0,1,0,0,0); check_main("ss_r2", 3'd5, R, R, PR);
        drive(0, 0,0,1,0,0); check_main("ss_mg", 3'd0, G, R, PG);
        drive(0, 1,0,0,0,0); check_main("ss_my3", 3'd1, Y, R, PY);
        drive(0, 0,1,0,0,0); check_main("ss_r1c", 3'd2, R, R, PR);
        drive(0, 0,0,1,0,0); check_main("ss_cleared", 3'd0, G, R, PG);
`endif

        @(negedge clk);
        rst_f = 1'b1; flash_f = 1'b1;
        @(posedge clk); #1;
        chk("fr_rst state", st_f, 3'd6);
        chk("fr_rst main", ml_f, Y);
        chk("fr_rst side", sl_f, Y);
        chk("fr_rst phase", {fg_f, fy_f, fr_f}, PR);
        @(negedge clk); rst_f = 1'b0;
        @(posedge clk); #1;
        chk("fr_t1 state", st_f, 3'd6);
        chk("fr_t1 main", ml_f, O);
        @(posedge clk); #1;
        chk("fr_t2 main", ml_f, Y);
        @(negedge clk); flash_f = 1'b0;
        @(posedge clk); #1;
        chk("fr_exit state", st_f, 3'd2);
        chk("fr_exit main", ml_f, R);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
